sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param_if.sv | 27 ++
 rtl/sync_fifo_param.sv | 66 ++++++
 tb/tb_sync_fifo_param.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read/status bundle for the parametrised sync FIFO
interface sync_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7
);
  logic [DATA_W-1:0] wrt_data;
  logic              wrt_en;
  logic              full;
  logic              almost_full;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;
  modport master (
    output wrt_data, wrt_en, rd_en, clr_err,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wrt_data, wrt_en, rd_en, clr_err,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered count/flags, sticky errors, optional FWFT
module sync_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 7,
  parameter int AFULL_TH  = 120,
  parameter int AEMPTY_TH = 8,
  parameter int FWFT      = 0
) (
  input logic clk,
  input logic rst,
  sync_fifo_param_if.slave b
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE = AEMPTY_TH[ADDR_W:0];
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr, cnt, cnt_nxt;
  logic              wr_ok, rd_ok;
  logic              empty_q, full_q, af_q, ae_q, of_q, uf_q, rv_q;
  logic [DATA_W-1:0] rd_q, head;
  always_comb begin
    wr_ok   = b.wrt_en && !full_q;
    rd_ok   = b.rd_en && !empty_q;
    cnt_nxt = cnt + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
    head    = mem[rd_ptr[ADDR_W-1:0]];
  end
  always_ff @(posedge clk)
    if (!rst && wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= b.wrt_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (rd_ok) rd_q <= head;
      rv_q    <= rd_ok;
      cnt     <= cnt_nxt;
      empty_q <= cnt_nxt == '0;
      full_q  <= cnt_nxt[ADDR_W];
      af_q    <= cnt_nxt >= AF;
      ae_q    <= cnt_nxt <= AE;
      // a new error in the same cycle as clr_err must survive the clear
      of_q    <= (b.wrt_en && full_q) || (of_q && !b.clr_err);
      uf_q    <= (b.rd_en && empty_q) || (uf_q && !b.clr_err);
    end
  end
  assign b.rd_data      = FWFT != 0 ? head : rd_q;
  assign b.rd_valid     = FWFT != 0 ? !empty_q : rv_q;
  assign b.count        = cnt;
  assign b.empty        = empty_q;
  assign b.full         = full_q;
  assign b.almost_full  = af_q;
  assign b.almost_empty = ae_q;
  assign b.overflow     = of_q;
  assign b.underflow    = uf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed vectors for standard-read and FWFT instances of sync_fifo_param
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(7)) f0 ();
  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(7)) f1 ();
  sync_fifo_param #(.FWFT(0)) dut0 (.clk(clk), .rst(rst), .b(f0.slave));
  sync_fifo_param #(.FWFT(1)) dut1 (.clk(clk), .rst(rst), .b(f1.slave));
  logic [5:0] fl0;
  assign fl0 = {f0.empty, f0.almost_empty, f0.almost_full, f0.full, f0.overflow, f0.underflow};
  typedef struct {
    logic        wen;
    logic [15:0] wd;
    logic        ren;
    logic        clr;
    logic [7:0]  cnt;
    logic [5:0]  fl;
    logic        rv;
    logic        dchk;
    logic [15:0] rd;
  } vec_t;
  vec_t tbl [15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] rdx, wx;
    {f0.wrt_en, f0.rd_en, f0.clr_err, f0.wrt_data} = '0;
    {f1.wrt_en, f1.rd_en, f1.clr_err, f1.wrt_data} = '0;
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 16'(i+1), 1'b0, 1'b0, 8'(i+1), 6'b010000, 1'b0, 1'b0, 16'h0};
    for (int i = 5; i < 10; i++)
      tbl[i] = '{1'b0, 16'h0, 1'b1, 1'b0, 8'(9-i), (i == 9) ? 6'b110000 : 6'b010000, 1'b1, 1'b1, 16'(i-4)};
    tbl[10] = '{1'b0, 16'h0,  1'b0, 1'b0, 8'd0, 6'b110000, 1'b0, 1'b1, 16'h5};
    tbl[11] = '{1'b0, 16'h0,  1'b1, 1'b0, 8'd0, 6'b110001, 1'b0, 1'b0, 16'h0};
    tbl[12] = '{1'b0, 16'h0,  1'b0, 1'b1, 8'd0, 6'b110000, 1'b0, 1'b0, 16'h0};
    tbl[13] = '{1'b1, 16'h77, 1'b1, 1'b0, 8'd1, 6'b010001, 1'b0, 1'b0, 16'h0};
    tbl[14] = '{1'b0, 16'h0,  1'b1, 1'b1, 8'd0, 6'b110000, 1'b1, 1'b1, 16'h77};
    step();
    step();
    rst = 1'b0;
    chk("rst_count", 32'(f0.count), 0);
    chk("rst_flags", 32'(fl0), 32'b110000);
    chk("rst_rv", 32'(f0.rd_valid), 0);
    chk("rst_rdata", 32'(f0.rd_data), 0);
    chk("fwft_rst_rv", 32'(f1.rd_valid), 0);
    // FWFT: head word visible the cycle after its write without any rd_en
    f1.wrt_en = 1'b1; f1.wrt_data = 16'hABCD;
    step();
    f1.wrt_en = 1'b0;
    chk("fwft_rv", 32'(f1.rd_valid), 1);
    chk("fwft_data", 32'(f1.rd_data), 32'hABCD);
    chk("fwft_empty", 32'(f1.empty), 0);
    f1.wrt_en = 1'b1; f1.wrt_data = 16'h1234;
    step();
    f1.wrt_en = 1'b0;
    chk("fwft_hold", 32'(f1.rd_data), 32'hABCD);
    f1.rd_en = 1'b1;
    step();
    chk("fwft_next", 32'(f1.rd_data), 32'h1234);
    chk("fwft_rv2", 32'(f1.rd_valid), 1);
    step();
    f1.rd_en = 1'b0;
    chk("fwft_pop_rv", 32'(f1.rd_valid), 0);
    chk("fwft_pop_empty", 32'(f1.empty), 1);
    for (int i = 0; i < 15; i++) begin
      f0.wrt_en = tbl[i].wen; f0.wrt_data = tbl[i].wd; f0.rd_en = tbl[i].ren; f0.clr_err = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_count", i), 32'(f0.count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_flags", i), 32'(fl0), 32'(tbl[i].fl));
      chk($sformatf("vec%0d_rv", i), 32'(f0.rd_valid), 32'(tbl[i].rv));
      if (tbl[i].dchk) chk($sformatf("vec%0d_rdata", i), 32'(f0.rd_data), 32'(tbl[i].rd));
    end
    {f0.wrt_en, f0.rd_en, f0.clr_err} = '0;
    for (int i = 1; i <= 128; i++) begin
      f0.wrt_en = 1'b1; f0.wrt_data = 16'(16'h100 + i);
      step();
      if (i == 8 || i == 9) chk($sformatf("ae_at_%0d", i), 32'(f0.almost_empty), 32'(i == 8));
      if (i == 119 || i == 120) chk($sformatf("af_at_%0d", i), 32'(f0.almost_full), 32'(i == 120));
      if (i == 127 || i == 128) chk($sformatf("full_at_%0d", i), 32'(f0.full), 32'(i == 128));
    end
    chk("fill_count", 32'(f0.count), 128);
    f0.wrt_data = 16'hDEAD;
    step();
    chk("ovf_set", 32'(f0.overflow), 1);
    chk("ovf_count", 32'(f0.count), 128);
    f0.rd_en = 1'b1;
    step();
    f0.wrt_en = 1'b0; f0.rd_en = 1'b0;
    chk("full_rw_count", 32'(f0.count), 127);
    chk("full_rw_full", 32'(f0.full), 0);
    chk("full_rw_rv", 32'(f0.rd_valid), 1);
    chk("full_rw_data", 32'(f0.rd_data), 32'h101);
    f0.clr_err = 1'b1;
    step();
    f0.clr_err = 1'b0;
    chk("clr_ovf", 32'(f0.overflow), 0);
    rdx = 16'h102;
    f0.rd_en = 1'b1;
    for (int i = 0; i < 63; i++) begin
      step();
      chk("drain_data", 32'(f0.rd_data), 32'(rdx));
      rdx++;
    end
    chk("drain_count", 32'(f0.count), 64);
    wx = 16'h181;
    f0.wrt_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      f0.wrt_data = wx;
      wx++;
      step();
      chk("stream_count", 32'(f0.count), 64);
      chk("stream_data", 32'(f0.rd_data), 32'(rdx));
      chk("stream_flags", 32'(fl0), 0);
      rdx++;
    end
    chk("stream_rv", 32'(f0.rd_valid), 1);
    f0.wrt_en = 1'b0;
    for (int i = 0; i < 27; i++) begin
      step();
      chk("pre_rst_data", 32'(f0.rd_data), 32'(rdx));
      rdx++;
    end
    chk("pre_rst_count", 32'(f0.count), 37);
    rst = 1'b1; f0.wrt_en = 1'b1; f0.wrt_data = 16'hBEEF;
    step();
    rst = 1'b0; f0.rd_en = 1'b0; f0.wrt_data = 16'h5A5A;
    chk("mid_rst_count", 32'(f0.count), 0);
    chk("mid_rst_flags", 32'(fl0), 32'b110000);
    chk("mid_rst_rv", 32'(f0.rd_valid), 0);
    step();
    f0.wrt_en = 1'b0; f0.rd_en = 1'b1;
    chk("post_rst_count", 32'(f0.count), 1);
    step();
    f0.rd_en = 1'b0;
    chk("post_rst_rv", 32'(f0.rd_valid), 1);
    chk("post_rst_data", 32'(f0.rd_data), 32'h5A5A);
    chk("post_rst_empty", 32'(f0.empty), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
